// File: rtl/datapath_ctrl_pkg.sv
// Shared definitions for the datapath controller: opcodes, ALU/shift codes, FSM states.
// Build option ILLEGAL_TRAP_EN adds a sticky TRAP state for illegal instructions.
package datapath_ctrl_pkg;

  localparam int IR_W = 16;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_MOVR = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_MVN  = 2'b11;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_NOT} aluop_e;
  typedef enum logic [1:0] {NO_SHIFT, LS, RS_MSB_0, RS_MSB_CP} shift_e;

  typedef enum logic [2:0] {
    S_WAIT, S_WR_IMM, S_GET_A, S_GET_B, S_ALU, S_WR_RD
`ifdef ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_e;

  typedef enum logic [2:0] {I_MOVI, I_MOVR, I_ADD, I_CMP, I_AND, I_MVN, I_ILL} instr_e;

  typedef struct packed {
    instr_e          kind;
    logic            legal;
    logic [2:0]      rn;
    logic [2:0]      rd;
    logic [1:0]      sh;
    logic [2:0]      rm;
    logic [IR_W-1:0] sximm8;
  } dec_t;

  function automatic logic [IR_W-1:0] sext8(input logic [7:0] v);
    return {{(IR_W-8){v[7]}}, v};
  endfunction

endpackage

// File: rtl/datapath_ctrl_if.sv
// Fetch-side handshake plus the control bundle driven into the register-file/ALU datapath.
interface datapath_ctrl_if;
  import datapath_ctrl_pkg::*;

  logic            load;
  logic [IR_W-1:0] in;
  logic            s;
  logic            w;
  logic [2:0]      readnum;
  logic [2:0]      writenum;
  logic            write;
  logic            loada;
  logic            loadb;
  logic            loadc;
  logic            loads;
  logic            vsel;
  logic            asel;
  logic            bsel;
  logic [1:0]      ALUop;
  logic [1:0]      shift;
  logic [IR_W-1:0] sximm8;
  logic            trap;

  modport slave (
    input  load, in, s,
    output w, readnum, writenum, write, loada, loadb, loadc, loads,
           vsel, asel, bsel, ALUop, shift, sximm8, trap
  );

  modport master (
    output load, in, s,
    input  w, readnum, writenum, write, loada, loadb, loadc, loads,
           vsel, asel, bsel, ALUop, shift, sximm8, trap
  );
endinterface

// File: rtl/datapath_ctrl_instr_decode.sv
// Combinational instruction decode: field extraction, imm8 sign extension, legality.
module instr_decode
  import datapath_ctrl_pkg::*;
(
  input  logic [IR_W-1:0] i_ir,
  output dec_t            o_dec
);

  always_comb begin
    o_dec.kind   = I_ILL;
    o_dec.rn     = i_ir[10:8];
    o_dec.rd     = i_ir[7:5];
    o_dec.sh     = i_ir[4:3];
    o_dec.rm     = i_ir[2:0];
    o_dec.sximm8 = sext8(i_ir[7:0]);
    case (i_ir[15:13])
      OPC_MOV: begin
        if (i_ir[12:11] == OP_MOVI)      o_dec.kind = I_MOVI;
        else if (i_ir[12:11] == OP_MOVR) o_dec.kind = I_MOVR;
      end
      OPC_ALU: begin
        case (i_ir[12:11])
          OP_ADD:  o_dec.kind = I_ADD;
          OP_CMP:  o_dec.kind = I_CMP;
          OP_AND:  o_dec.kind = I_AND;
          default: o_dec.kind = I_MVN;
        endcase
      end
      default: o_dec.kind = I_ILL;
    endcase
    o_dec.legal = (o_dec.kind != I_ILL);
  end

endmodule

// File: rtl/datapath_ctrl.sv
// Instruction-sequencing controller: IR, Moore FSM and control decode for the datapath.
// Define ILLEGAL_TRAP_EN to make illegal instructions lock the controller in TRAP.
module datapath_ctrl
  import datapath_ctrl_pkg::*;
(
  input logic            clk,
  input logic            reset_n,
  datapath_ctrl_if.slave bus
);

  logic [IR_W-1:0] r_ir;
  state_e          r_state;
  state_e          w_next;
  dec_t            w_dec;

  logic       w_w, w_write, w_loada, w_loadb, w_loadc, w_loads, w_vsel, w_asel;
  logic [2:0] w_readnum, w_writenum;
  aluop_e     w_aluop;
  shift_e     w_shift;

  instr_decode u_dec (.i_ir(r_ir), .o_dec(w_dec));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_WAIT;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_WAIT && bus.load) r_ir <= bus.in;
    end
  end

  // A load in WAIT takes priority over s so a fresh IR is never launched in the same edge.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_WAIT: begin
        if (!bus.load && bus.s) begin
          if (!w_dec.legal) begin
`ifdef ILLEGAL_TRAP_EN
            w_next = S_TRAP;
`else
            w_next = S_WAIT;
`endif
          end else begin
            case (w_dec.kind)
              I_MOVI:             w_next = S_WR_IMM;
              I_ADD, I_AND, I_CMP: w_next = S_GET_A;
              default:            w_next = S_GET_B;
            endcase
          end
        end
      end
      S_WR_IMM: w_next = S_WAIT;
      S_GET_A:  w_next = S_GET_B;
      S_GET_B:  w_next = S_ALU;
      S_ALU:    w_next = (w_dec.kind == I_CMP) ? S_WAIT : S_WR_RD;
      S_WR_RD:  w_next = S_WAIT;
      default:  w_next = r_state;
    endcase
  end

  always_comb begin
    w_w        = 1'b0;
    w_readnum  = '0;
    w_writenum = '0;
    w_write    = 1'b0;
    w_loada    = 1'b0;
    w_loadb    = 1'b0;
    w_loadc    = 1'b0;
    w_loads    = 1'b0;
    w_vsel     = 1'b0;
    w_asel     = 1'b0;
    w_aluop    = ALU_ADD;
    w_shift    = NO_SHIFT;
    case (r_state)
      S_WAIT: w_w = 1'b1;
      S_WR_IMM: begin
        w_writenum = w_dec.rn;
        w_write    = 1'b1;
        w_vsel     = 1'b1;
      end
      S_GET_A: begin
        w_readnum = w_dec.rn;
        w_loada   = 1'b1;
      end
      S_GET_B: begin
        w_readnum = w_dec.rm;
        w_loadb   = 1'b1;
      end
      S_ALU: begin
        w_shift = shift_e'(w_dec.sh);
        case (w_dec.kind)
          I_CMP: begin
            w_aluop = ALU_SUB;
            w_loads = 1'b1;
          end
          I_AND: begin
            w_aluop = ALU_AND;
            w_loadc = 1'b1;
          end
          I_MVN: begin
            w_aluop = ALU_NOT;
            w_asel  = 1'b1;
            w_loadc = 1'b1;
          end
          I_MOVR: begin
            w_asel  = 1'b1;
            w_loadc = 1'b1;
          end
          default: w_loadc = 1'b1;
        endcase
      end
      S_WR_RD: begin
        w_writenum = w_dec.rd;
        w_write    = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.w        = w_w;
  assign bus.readnum  = w_readnum;
  assign bus.writenum = w_writenum;
  assign bus.write    = w_write;
  assign bus.loada    = w_loada;
  assign bus.loadb    = w_loadb;
  assign bus.loadc    = w_loadc;
  assign bus.loads    = w_loads;
  assign bus.vsel     = w_vsel;
  assign bus.asel     = w_asel;
  assign bus.bsel     = 1'b0;
  assign bus.ALUop    = w_aluop;
  assign bus.shift    = w_shift;
  assign bus.sximm8   = w_dec.sximm8;
`ifdef ILLEGAL_TRAP_EN
  assign bus.trap     = (r_state == S_TRAP);
`else
  assign bus.trap     = 1'b0;
`endif

endmodule

// File: tb/tb_datapath_ctrl.sv
// Directed plus randomized bench for datapath_ctrl against a micro-step sequence model.
module tb_datapath_ctrl;
  import datapath_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  datapath_ctrl_if bus();
  datapath_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct packed {
    logic       w;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       write, loada, loadb, loadc, loads, vsel, asel, bsel;
    logic [1:0] aluop;
    logic [1:0] shift;
    logic       trap;
  } ctl_t;

  int   total = 0;
  int   bad   = 0;
  ctl_t exp_q[$];

  function automatic ctl_t idle();
    ctl_t c = '0;
    c.w = 1'b1;
    return c;
  endfunction

  function automatic ctl_t act();
    ctl_t c;
    c = {bus.w, bus.readnum, bus.writenum, bus.write, bus.loada, bus.loadb, bus.loadc,
         bus.loads, bus.vsel, bus.asel, bus.bsel, bus.ALUop, bus.shift, bus.trap};
    return c;
  endfunction

  function automatic logic [15:0] sx(input logic [15:0] i);
    logic [15:0] r;
    r = 16'(signed'(i[7:0]));
    return r;
  endfunction

  function automatic bit is_legal(input logic [15:0] i);
    return (i[15:13] == 3'b101) || (i[15:13] == 3'b110 && i[11] == 1'b0);
  endfunction

  task automatic chk(input string tag, input ctl_t e, input logic [15:0] s8);
    ctl_t a;
    a = act();
    total++;
    assert (a === e) else begin
      bad++;
      $error("FAIL %s ctl got=%h exp=%h", tag, a, e);
    end
    total++;
    assert (bus.sximm8 === s8) else begin
      bad++;
      $error("FAIL %s sximm8 got=%h exp=%h", tag, bus.sximm8, s8);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected per-cycle control vectors for one instruction, written as the datapath steps.
  task automatic build(input logic [15:0] i);
    ctl_t c;
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op, sh;
    bit movr, mvn, cmp;
    opc = i[15:13]; op = i[12:11]; rn = i[10:8]; rd = i[7:5]; sh = i[4:3]; rm = i[2:0];
    exp_q.delete();
    if (!is_legal(i)) return;
    if (opc == 3'b110 && op == 2'b10) begin
      c = '0; c.writenum = rn; c.write = 1; c.vsel = 1;
      exp_q.push_back(c);
      return;
    end
    movr = (opc == 3'b110);
    mvn  = (opc == 3'b101 && op == 2'b11);
    cmp  = (opc == 3'b101 && op == 2'b01);
    if (!movr && !mvn) begin
      c = '0; c.readnum = rn; c.loada = 1; exp_q.push_back(c);
    end
    c = '0; c.readnum = rm; c.loadb = 1; exp_q.push_back(c);
    c = '0; c.shift = sh; c.asel = movr || mvn;
    if (movr)                      c.aluop = 2'b00;
    else if (mvn)                  c.aluop = 2'b11;
    else if (cmp)                  c.aluop = 2'b01;
    else if (op == 2'b10)          c.aluop = 2'b10;
    else                           c.aluop = 2'b00;
    if (cmp) c.loads = 1; else c.loadc = 1;
    exp_q.push_back(c);
    if (!cmp) begin
      c = '0; c.writenum = rd; c.write = 1; exp_q.push_back(c);
    end
  endtask

  task automatic run(input string tag, input logic [15:0] i);
    bus.load = 1; bus.in = i; tick();
    bus.load = 0; bus.s = 1; tick();
    bus.s = 0;
    build(i);
    foreach (exp_q[k]) begin
      chk(tag, exp_q[k], sx(i));
      tick();
    end
    chk({tag, "_end"}, idle(), sx(i));
  endtask

  initial begin
    logic [15:0] ins;
    ctl_t tv;
    bus.load = 0; bus.in = '0; bus.s = 0;
    #1 chk("reset", idle(), 16'h0000);
    #10 reset_n = 1;
    tick();
    chk("post_reset", idle(), 16'h0000);

    run("movi_r2", 16'hD220);
    run("movi_m7", 16'hD0F9);
    run("add_lsl", 16'hA148);
    run("cmp", 16'hAD02);
    run("and", 16'hB3F6);
    run("movr", 16'hC0B5);
    run("mvn", 16'hB8F3);

    // load and s together: IR loads, no launch
    bus.load = 1; bus.s = 1; bus.in = 16'hD220; tick();
    bus.load = 0; bus.s = 0;
    chk("load_and_s", idle(), 16'h0020);
    tick();
    chk("load_and_s2", idle(), 16'h0020);

    // s held high relaunches on each WAIT cycle
    build(16'hD220);
    bus.s = 1; tick();
    chk("hold_s_1", exp_q[0], 16'h0020);
    tick();
    chk("hold_s_wait", idle(), 16'h0020);
    tick();
    chk("hold_s_2", exp_q[0], 16'h0020);
    bus.s = 0; tick();
    chk("hold_s_end", idle(), 16'h0020);

    // load while busy is ignored
    bus.load = 1; bus.in = 16'hA148; tick();
    bus.load = 0; bus.s = 1; tick();
    bus.s = 0; bus.load = 1; bus.in = 16'hD220;
    build(16'hA148);
    foreach (exp_q[k]) begin
      chk("busy_load", exp_q[k], 16'h0048);
      tick();
    end
    bus.load = 0;
    chk("busy_load_end", idle(), 16'h0048);

    // reset in GET_B aborts with no write
    bus.s = 1; tick();
    bus.s = 0; tick();
    chk("abort_getb", exp_q[1], 16'h0048);
    reset_n = 0;
    #1 chk("abort_reset", idle(), 16'h0000);
    #2 reset_n = 1;
    tick();
    chk("abort_after", idle(), 16'h0000);
    tick();
    chk("abort_after2", idle(), 16'h0000);

    for (int n = 0; n < 40; n++) begin
      ins = 16'($urandom);
      case ($urandom_range(0, 5))
        0: ins[15:11] = 5'b11010;
        1: ins[15:11] = 5'b11000;
        2: ins[15:11] = 5'b10100;
        3: ins[15:11] = 5'b10101;
        4: ins[15:11] = 5'b10110;
        default: ins[15:11] = 5'b10111;
      endcase
      run("rand_legal", ins);
    end

`ifndef ILLEGAL_TRAP_EN
    for (int n = 0; n < 10; n++) begin
      do ins = 16'($urandom); while (is_legal(ins));
      run("rand_illegal", ins);
      tick();
      chk("rand_illegal_2", idle(), sx(ins));
    end
    run("illegal_e000", 16'hE000);
    tick();
    chk("illegal_e000_2", idle(), 16'h0000);
`else
    bus.load = 1; bus.in = 16'hE000; tick();
    bus.load = 0; bus.s = 1; tick();
    bus.s = 0;
    tv = '0; tv.trap = 1;
    for (int n = 0; n < 5; n++) begin
      chk("trap_hold", tv, 16'h0000);
      bus.load = 1; bus.in = 16'hD220; bus.s = 1;
      tick();
    end
    bus.load = 0; bus.s = 0;
    reset_n = 0;
    #1 chk("trap_reset", idle(), 16'h0000);
    #2 reset_n = 1;
    tick();
    run("trap_recover", 16'hD220);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end

endmodule
